// File: rtl/key_input_pkg.sv
// Shared types and constants for the key input controller.
// Optional feature macro: KEY_AUTOREPEAT_EN (enables HOLD->REPEAT auto-repeat).
package key_input_pkg;

   // Counter widths for the debounce and hold/repeat timers
   localparam int DEB_CNT_W = 16;
   localparam int REP_CNT_W = 24;

   // Debounced channels: [0] up key, [1] down key, [4:2] select switches
   localparam int NUM_DEB  = 5;
   localparam int NUM_KEYS = 2;

   // Per-key press FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS  = 2'd1,
      HOLD   = 2'd2,
      REPEAT = 2'd3
   } key_state_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [REP_CNT_W-1:0] rep_sat_inc(input logic [REP_CNT_W-1:0] v);
      return (v == '1) ? v : v + REP_CNT_W'(1);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One-bit synchronizer plus debouncer.
// deb_o follows the synchronized input only after it has disagreed with the
// current debounced level for DEBOUNCE_CYCLES consecutive cycles; chg_o is a
// one-cycle flag raised in the same cycle deb_o takes its new value.
module key_debounce
   import key_input_pkg::*;
#(
   parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic deb_o,
   output logic chg_o
);

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEBOUNCE_CYCLES - DEB_CNT_W'(1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 deb_q;
   logic                 deb_d;
   logic                 chg_q;
   logic                 chg_d;
   logic [DEB_CNT_W-1:0] cnt_q;
   logic [DEB_CNT_W-1:0] cnt_d;

   // Two-flop synchronizer for the asynchronous raw input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive mismatch cycles; accept the new level on the last one
   always_comb begin
      deb_d = deb_q;
      chg_d = 1'b0;
      cnt_d = cnt_q;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q >= DEB_LAST) begin
         deb_d = sync2_q;
         chg_d = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DEB_CNT_W'(1);
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= 1'b0;
         chg_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         chg_q <= chg_d;
         cnt_q <= cnt_d;
      end
   end

   assign deb_o = deb_q;
   assign chg_o = chg_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Key input controller: debounces the up/down keys and the 3-bit select
// switches, and turns key presses into single-cycle up/down pulses.
// Optional feature macro: KEY_AUTOREPEAT_EN. When defined, a key held for
// REPEAT_DELAY_CYCLES starts auto-repeating every REPEAT_RATE_CYCLES; when
// undefined, each press yields exactly one pulse and no repeat timers exist.
// Holding both keys suppresses all pulses until both are released again.
module key_input_ctrl
   import key_input_pkg::*;
#(
   parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES     = 16'd50000,
   parameter logic [REP_CNT_W-1:0] REPEAT_DELAY_CYCLES = 24'd5000000,
   parameter logic [REP_CNT_W-1:0] REPEAT_RATE_CYCLES  = 24'd1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   input  logic [2:0] sw_sel_raw,
   output logic       up,
   output logic       down,
   output logic [2:0] sel,
   output logic       sel_chg
);

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [REP_CNT_W-1:0] DELAY_LAST = REPEAT_DELAY_CYCLES - REP_CNT_W'(1);
   localparam logic [REP_CNT_W-1:0] RATE_LAST  = REPEAT_RATE_CYCLES - REP_CNT_W'(1);
`else
   // Repeat timing is irrelevant in single-pulse mode
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES};
`endif

   logic [NUM_DEB-1:0]  raw_vec;
   logic [NUM_DEB-1:0]  deb_vec;
   logic [NUM_DEB-1:0]  chg_vec;
   logic [NUM_KEYS-1:0] pulse;
   logic                both_held;
   logic                block;
   logic                lock_q;
   logic                lock_d;

   assign raw_vec = {sw_sel_raw, btn_down_raw, btn_up_raw};

   // One synchronizer/debouncer per raw input bit
   for (genvar i = 0; i < NUM_DEB; i++) begin : g_deb
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk   (clk),
         .rst_n (rst_n),
         .raw_i (raw_vec[i]),
         .deb_o (deb_vec[i]),
         .chg_o (chg_vec[i])
      );
   end

   // Both keys held: block now, and keep blocking until both are released
   assign both_held = deb_vec[0] & deb_vec[1];
   assign block     = lock_q | both_held;

   // Lockout next-state: set on both-held, cleared once both keys are low
   always_comb begin
      lock_d = lock_q;
      if (both_held) begin
         lock_d = 1'b1;
      end else if (!deb_vec[0] && !deb_vec[1]) begin
         lock_d = 1'b0;
      end
   end

   // Lockout register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end

   // Press FSM per key: [0] up, [1] down
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_state_e state_q;
      key_state_e state_d;
      logic       rise;
      logic       fall;
      logic       pulse_c;
`ifdef KEY_AUTOREPEAT_EN
      logic [REP_CNT_W-1:0] hold_q;
      logic [REP_CNT_W-1:0] hold_d;
      logic [REP_CNT_W-1:0] rate_q;
      logic [REP_CNT_W-1:0] rate_d;
`endif

      assign rise = deb_vec[k] & chg_vec[k];
      assign fall = ~deb_vec[k] & chg_vec[k];

      // Next-state and pulse decode; lockout and release win over everything
      always_comb begin
         state_d = state_q;
         pulse_c = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         hold_d  = hold_q;
         rate_d  = rate_q;
`endif
         if (block || fall) begin
            state_d = IDLE;
`ifdef KEY_AUTOREPEAT_EN
            hold_d  = '0;
            rate_d  = '0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise) begin
                     pulse_c = 1'b1;
                     state_d = PRESS;
                  end
               end
               PRESS: begin
                  state_d = HOLD;
`ifdef KEY_AUTOREPEAT_EN
                  hold_d  = '0;
`endif
               end
               HOLD: begin
`ifdef KEY_AUTOREPEAT_EN
                  if (hold_q >= DELAY_LAST) begin
                     pulse_c = 1'b1;
                     state_d = REPEAT;
                     rate_d  = '0;
                  end else begin
                     hold_d = rep_sat_inc(hold_q);
                  end
`else
                  state_d = HOLD;
`endif
               end
               REPEAT: begin
`ifdef KEY_AUTOREPEAT_EN
                  if (rate_q >= RATE_LAST) begin
                     pulse_c = 1'b1;
                     rate_d  = '0;
                  end else begin
                     rate_d = rep_sat_inc(rate_q);
                  end
`else
                  state_d = IDLE;
`endif
               end
               default: state_d = IDLE;
            endcase
         end
      end

      // FSM state and repeat timers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
            hold_q  <= '0;
            rate_q  <= '0;
`endif
         end else begin
            state_q <= state_d;
`ifdef KEY_AUTOREPEAT_EN
            hold_q  <= hold_d;
            rate_q  <= rate_d;
`endif
         end
      end

      assign pulse[k] = pulse_c;
   end

   assign up      = pulse[0];
   assign down    = pulse[1];
   assign sel     = deb_vec[4:2];
   assign sel_chg = |chg_vec[4:2];

endmodule
